// File: rtl/aes_stream_pkg.sv
// Shared constants for the AES word-stream producer/consumer pair.
// Holds the FIFO word and block widths, words per block, the image block
// count (512*512*3/16), the default FIFO occupancy ceiling and the producer
// state encoding (also exported on the debug state port).
package aes_stream_pkg;

  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned BLOCK_W_DEF     = DATA_W_DEF * WORDS_PER_BLOCK;
  localparam int unsigned FIFO_LIMIT_DEF  = 256;
  localparam logic [15:0] IMAGE_BLOCKS    = 16'hC000;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitBlk  = 3'd1,
    StWaitRoom = 3'd2,
    StSend     = 3'd3,
    StGap      = 3'd4,
    StCheck    = 3'd5,
    StDone     = 3'd6
  } tx_state_e;

endpackage

// File: rtl/block_word_mux.sv
// Combinational word select: returns word idx_i of a packed block, where
// word 0 is the least-significant DATA_W bits.
// Ports:
//   block_i  packed block, WORDS words of DATA_W bits
//   idx_i    word index
//   word_o   selected word
module block_word_mux #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORDS  = 8
) (
  input  logic [DATA_W*WORDS-1:0] block_i,
  input  logic [2:0]              idx_i,
  output logic [DATA_W-1:0]       word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_i == 3'(i)) begin
        word_o = block_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/aes_block_word_tx.sv
// Producer end of the 16-bit word FIFO feeding the AES path. Accepts 128-bit
// blocks over valid/ready, writes each as eight FIFO words (LS word first,
// one strobe every other cycle), meters blocks against FIFO occupancy and
// counts blocks up to TOTAL_BLOCKS, then raises a sticky done flag.
// Ports:
//   iCLK, iRST_n       clock, synchronous active-low reset
//   iSTART             run start; honoured only in IDLE and DONE
//   iBLOCK_VALID/iBLOCK, oBLOCK_READY   upstream block handshake
//   iFIFO_USEDW, iFIFO_BUSY            FIFO fill level and controller hold-off
//   oWRITE, oWRITEDATA                 FIFO write strobe and data
//   oDONE, oBLOCK_COUNT, oSTATE        run status and debug state
module aes_block_word_tx
  import aes_stream_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned BLOCK_W      = BLOCK_W_DEF,
  parameter int unsigned USEDW_W      = 16,
  parameter int unsigned FIFO_LIMIT   = FIFO_LIMIT_DEF,
  parameter logic [15:0] TOTAL_BLOCKS = IMAGE_BLOCKS
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iSTART,
  input  logic               iBLOCK_VALID,
  input  logic [BLOCK_W-1:0] iBLOCK,
  output logic               oBLOCK_READY,
  input  logic [USEDW_W-1:0] iFIFO_USEDW,
  input  logic               iFIFO_BUSY,
  output logic               oWRITE,
  output logic [DATA_W-1:0]  oWRITEDATA,
  output logic               oDONE,
  output logic [15:0]        oBLOCK_COUNT,
  output logic [2:0]         oSTATE
);

  localparam logic [2:0] LastIdx = 3'(WORDS_PER_BLOCK - 1);

  tx_state_e          state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               done_q, done_d;
  logic [15:0]        count_q, count_d;

  logic [DATA_W-1:0]  cur_word;
  logic [USEDW_W:0]   usedw_plus_blk;
  logic               room;
  logic [15:0]        count_inc;

  block_word_mux #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS_PER_BLOCK)
  ) u_word_mux (
    .block_i (block_q),
    .idx_i   (idx_q),
    .word_o  (cur_word)
  );

  // One extra bit so a nearly-full used-words count cannot wrap past the limit.
  // Room for a whole block is reserved up front, so a started block never stalls.
  assign usedw_plus_blk = {1'b0, iFIFO_USEDW} + (USEDW_W+1)'(WORDS_PER_BLOCK);
  assign room           = (usedw_plus_blk <= (USEDW_W+1)'(FIFO_LIMIT)) && !iFIFO_BUSY;
  assign count_inc      = count_q + 16'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    block_d = block_q;
    write_d = 1'b0;
    wdata_d = wdata_q;
    done_d  = done_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (iSTART) state_d = StWaitBlk;
      end
      StWaitBlk: begin
        if (iBLOCK_VALID) begin
          block_d = iBLOCK;
          idx_d   = 3'd0;
          state_d = StWaitRoom;
        end
      end
      StWaitRoom: begin
        if (room) begin
          write_d = 1'b1;
          wdata_d = cur_word;
          state_d = StGap;
        end
      end
      StSend: begin
        write_d = 1'b1;
        wdata_d = cur_word;
        state_d = StGap;
      end
      StGap: begin
        if (idx_q == LastIdx) begin
          state_d = StCheck;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StSend;
        end
      end
      StCheck: begin
        count_d = count_inc;
        if (count_inc == TOTAL_BLOCKS) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StWaitBlk;
        end
      end
      StDone: begin
        if (iSTART) begin
          done_d  = 1'b0;
          count_d = 16'd0;
          state_d = StWaitBlk;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      block_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      block_q <= block_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign oBLOCK_READY = (state_q == StWaitBlk);
  assign oWRITE       = write_q;
  assign oWRITEDATA   = wdata_q;
  assign oDONE        = done_q;
  assign oBLOCK_COUNT = count_q;
  assign oSTATE       = state_q;

endmodule

// File: tb/tb_aes_block_word_tx.sv
// Bench for aes_block_word_tx. A reference model tracks the run at the
// level of blocks: when a block is accepted its eight words are pushed into
// a scoreboard queue, the first-strobe cycle is fixed by the first sampled
// edge with room, and the rest of the block follows from the fixed strobe
// spacing. The monitor checks the outputs every cycle against that model.
module tb_aes_block_word_tx;
  import aes_stream_pkg::*;

  localparam logic [15:0] TbTotal = 16'd3;
  localparam int          TbLimit = 256;

  logic         iCLK;
  logic         iRST_n;
  logic         iSTART;
  logic         iBLOCK_VALID;
  logic [127:0] iBLOCK;
  logic         oBLOCK_READY;
  logic [15:0]  iFIFO_USEDW;
  logic         iFIFO_BUSY;
  logic         oWRITE;
  logic [15:0]  oWRITEDATA;
  logic         oDONE;
  logic [15:0]  oBLOCK_COUNT;
  logic [2:0]   oSTATE;

  aes_block_word_tx #(
    .TOTAL_BLOCKS (TbTotal)
  ) dut (
    .iCLK         (iCLK),
    .iRST_n       (iRST_n),
    .iSTART       (iSTART),
    .iBLOCK_VALID (iBLOCK_VALID),
    .iBLOCK       (iBLOCK),
    .oBLOCK_READY (oBLOCK_READY),
    .iFIFO_USEDW  (iFIFO_USEDW),
    .iFIFO_BUSY   (iFIFO_BUSY),
    .oWRITE       (oWRITE),
    .oWRITEDATA   (oWRITEDATA),
    .oDONE        (oDONE),
    .oBLOCK_COUNT (oBLOCK_COUNT),
    .oSTATE       (oSTATE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model, advanced once per cycle by the monitor.
  bit          mon_en      = 0;
  bit          m_run       = 0;  // started and not yet done
  bit          m_busy      = 0;  // a block is accepted and not yet counted
  bit          m_first_ok  = 0;  // first-strobe edge of current block known
  bit          m_done      = 0;
  int          m_count     = 0;
  int          m_acc       = 0;
  int          m_first     = 0;
  int          m_end       = 0;
  int          n;
  bit          exp_wr;
  logic [15:0] exp_q[$];

  always @(negedge iCLK) begin
    if (mon_en) begin
      n = cyc;
      // Block counted 16 edges after its first strobe edge.
      if (m_busy && m_first_ok && n == m_end) begin
        m_busy  = 0;
        m_count = m_count + 1;
        if (m_count == int'(TbTotal)) begin
          m_done = 1;
          m_run  = 0;
        end
      end
      exp_wr = m_busy && m_first_ok && n >= m_first && n <= m_first + 14 &&
               ((n - m_first) % 2 == 0);
      chk("ready", oBLOCK_READY, m_run && !m_busy);
      chk("count", oBLOCK_COUNT, m_count);
      chk("done", oDONE, m_done);
      chk("write", oWRITE, exp_wr);
      if (oWRITE && exp_wr) begin
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("wdata", oWRITEDATA, exp_q.pop_front());
      end
      // Apply the inputs that the next edge will sample.
      if (!iRST_n) begin
        m_run = 0; m_busy = 0; m_first_ok = 0; m_done = 0; m_count = 0;
        exp_q.delete();
      end else begin
        if (iSTART && !m_run && !m_busy) begin
          m_run = 1; m_done = 0; m_count = 0;
        end else if (m_run && !m_busy && iBLOCK_VALID) begin
          m_busy     = 1;
          m_first_ok = 0;
          m_acc      = n + 1;
          for (int k = 0; k < 8; k++) exp_q.push_back(iBLOCK[16*k +: 16]);
        end
        if (m_busy && !m_first_ok && n + 1 >= m_acc + 1 &&
            int'(iFIFO_USEDW) + 8 <= TbLimit && !iFIFO_BUSY) begin
          m_first    = n + 1;
          m_first_ok = 1;
          m_end      = m_first + 16;
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_start();
    iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
  endtask

  // Returns one time step after the accepting edge.
  task automatic send_block(input logic [127:0] b);
    bit ok;
    int guard;
    ok = 0;
    guard = 0;
    iBLOCK = b;
    iBLOCK_VALID = 1'b1;
    while (!ok && guard < 200) begin
      @(negedge iCLK);
      ok = oBLOCK_READY;
      guard++;
      @(posedge iCLK);
      #1;
    end
    if (!ok) chk("accept_timeout", ok, 1);
    iBLOCK_VALID = 1'b0;
    iBLOCK = rand128();  // must not affect the latched block
  endtask

  initial begin
    iRST_n = 1'b0; iSTART = 1'b0; iBLOCK_VALID = 1'b0; iBLOCK = '0;
    iFIFO_USEDW = '0; iFIFO_BUSY = 1'b0;
    tick(1);
    mon_en = 1;
    tick(2);
    chk("reset_state", oSTATE, StIdle);
    chk("reset_wdata", oWRITEDATA, 0);
    iRST_n = 1'b1;
    // Valid without start is ignored in IDLE.
    iBLOCK_VALID = 1'b1;
    tick(4);
    iBLOCK_VALID = 1'b0;

    // Basic block, empty FIFO.
    pulse_start();
    send_block(128'h0007_0006_0005_0004_0003_0002_0001_0000);
    tick(20);

    // Used-words one above the boundary, then exactly at it.
    iFIFO_USEDW = 16'd249;
    send_block(rand128());
    tick(10);
    iFIFO_USEDW = 16'd248;
    tick(20);

    // Controller busy stall; this block completes the run.
    iFIFO_USEDW = 16'd0;
    iFIFO_BUSY  = 1'b1;
    send_block(rand128());
    tick(5);
    iFIFO_BUSY = 1'b0;
    tick(22);

    // Restart from DONE; FIFO fills up after the 3rd strobe.
    pulse_start();
    send_block(rand128());
    tick(6);
    iFIFO_USEDW = 16'd300;
    iFIFO_BUSY  = 1'b1;
    tick(20);
    iFIFO_USEDW = 16'd0;
    iFIFO_BUSY  = 1'b0;

    // Full run with continuous valid, then restart from DONE.
    iRST_n = 1'b0;
    tick(1);
    iRST_n = 1'b1;
    pulse_start();
    iBLOCK_VALID = 1'b1;
    repeat (64) begin
      iBLOCK = rand128();
      tick(1);
    end
    iSTART = 1'b1;
    tick(1);
    iSTART = 1'b0;
    repeat (25) begin
      iBLOCK = rand128();
      tick(1);
    end
    iBLOCK_VALID = 1'b0;
    tick(2);

    // Reset during strobe 4, then valid with no start.
    send_block(rand128());
    tick(7);
    iRST_n = 1'b0;
    tick(1);
    iRST_n = 1'b1;
    chk("midrst_state", oSTATE, StIdle);
    chk("midrst_wdata", oWRITEDATA, 0);
    iBLOCK_VALID = 1'b1;
    tick(20);
    iBLOCK_VALID = 1'b0;

    // Start mid-block is ignored.
    pulse_start();
    send_block(rand128());
    tick(5);
    pulse_start();
    tick(20);

    // Random traffic around the room boundary.
    repeat (400) begin
      iFIFO_USEDW  = 16'($urandom_range(240, 260));
      iFIFO_BUSY   = ($urandom_range(0, 3) == 0);
      iBLOCK_VALID = $urandom_range(0, 1) == 1;
      iBLOCK       = rand128();
      iSTART       = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    iSTART = 1'b0;
    iBLOCK_VALID = 1'b0;
    iFIFO_BUSY = 1'b0;
    iFIFO_USEDW = '0;
    tick(40);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
